// File: rtl/pc_seq_pkg.sv
// Shared widths, defaults and FSM encodings for the fetch-stage PC sequencer.
package pc_seq_pkg;

   localparam int DEFAULT_PC_W         = 12;
   localparam int DEFAULT_FLUSH_CYCLES = 2;
   localparam int CNT_W                = 2;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/pc_reg_en.sv
// Enabled program-counter register; the asynchronous clear loads RESET_PC.
module pc_reg_en
   import pc_seq_pkg::*;
#(
   parameter int              PC_W     = DEFAULT_PC_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            en,
   input  logic [PC_W-1:0] d,
   output logic [PC_W-1:0] q
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q <= RESET_PC;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: redirect > halt > stall > increment, with a timed
// wrong-path flush window after every redirect and halt/resume control.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W         = DEFAULT_PC_W,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_target,
   input  logic            stall_i,
   input  logic            md_busy,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            flush_fd,
   output logic            flush_dx,
   output logic            pc_wrap,
   output logic [1:0]      state
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   seq_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             fetch_valid_reg, fetch_valid_next;
   logic             flush_reg, flush_next;
   logic             wrap_reg, wrap_next;
   logic             step_pc;
   logic             pc_en;
   logic [PC_W-1:0]  pc_d;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_inc;
   logic             busy;

   assign pc_inc = pc_q + PC_W'(1);
   assign busy   = stall_i | md_busy;

   // Only sequential increments can wrap; a redirect to 0 never reports one.
   assign pc_en     = redirect_valid | step_pc;
   assign pc_d      = redirect_valid ? redirect_target : pc_inc;
   assign wrap_next = step_pc & (&pc_q);

   pc_reg_en #(
      .PC_W    (PC_W),
      .RESET_PC(RESET_PC)
   ) u_pc_reg (
      .clk  (clk),
      .clr_n(clr_n),
      .en   (pc_en),
      .d    (pc_d),
      .q    (pc_q)
   );

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      fetch_valid_next = fetch_valid_reg;
      flush_next       = flush_reg;
      step_pc          = 1'b0;

      if (redirect_valid) begin
         state_next       = FLUSH;
         cnt_next         = CNT_LOAD;
         flush_next       = 1'b1;
         fetch_valid_next = 1'b1;
      end else begin
         case (state_reg)
            RUN: begin
               if (halt_req) begin
                  state_next       = HALT;
                  fetch_valid_next = 1'b0;
               end else if (busy) begin
                  state_next       = STALL;
                  fetch_valid_next = 1'b1;
               end else if (!fetch_valid_reg) begin
                  // First edge out of reset: start fetching at RESET_PC.
                  fetch_valid_next = 1'b1;
               end else begin
                  step_pc = 1'b1;
               end
            end
            STALL: begin
               if (halt_req) begin
                  state_next       = HALT;
                  fetch_valid_next = 1'b0;
               end else if (!busy) begin
                  state_next = RUN;
                  step_pc    = 1'b1;
               end
            end
            FLUSH: begin
               // stall_i originates from the instructions being flushed.
               step_pc = !md_busy;
               if (cnt_reg == '0) begin
                  state_next = RUN;
                  flush_next = 1'b0;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            HALT: begin
               if (resume) begin
                  state_next       = RUN;
                  fetch_valid_next = 1'b1;
               end
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg       <= RUN;
         cnt_reg         <= '0;
         fetch_valid_reg <= 1'b0;
         flush_reg       <= 1'b0;
         wrap_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         fetch_valid_reg <= fetch_valid_next;
         flush_reg       <= flush_next;
         wrap_reg        <= wrap_next;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = fetch_valid_reg;
   assign flush_fd    = flush_reg;
   assign flush_dx    = flush_reg;
   assign pc_wrap     = wrap_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario tests plus a randomized run against a behavioural PC model.
module tb_pc_sequencer;

   localparam int PC_W = 12;
   localparam int FC   = 2;

   logic            clk = 1'b0;
   logic            clr_n = 1'b1;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_target;
   logic            stall_i;
   logic            md_busy;
   logic            halt_req;
   logic            resume;
   logic [PC_W-1:0] pc;
   logic            fetch_valid;
   logic            flush_fd;
   logic            flush_dx;
   logic            pc_wrap;
   logic [1:0]      state;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model: mode 0 run, 1 stall, 2 flush, 3 halt
   int m_pc, m_mode, m_left;
   bit m_fv, m_started, m_wrap;

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_W        (PC_W),
      .RESET_PC    (12'h000),
      .FLUSH_CYCLES(FC)
   ) dut (
      .clk            (clk),
      .clr_n          (clr_n),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .stall_i        (stall_i),
      .md_busy        (md_busy),
      .halt_req       (halt_req),
      .resume         (resume),
      .pc             (pc),
      .fetch_valid    (fetch_valid),
      .flush_fd       (flush_fd),
      .flush_dx       (flush_dx),
      .pc_wrap        (pc_wrap),
      .state          (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      redirect_valid  = 1'b0;
      redirect_target = '0;
      stall_i         = 1'b0;
      md_busy         = 1'b0;
      halt_req        = 1'b0;
      resume          = 1'b0;
   endtask

   task automatic run_to(input logic [PC_W-1:0] target);
      int n;
      n = 0;
      while (pc !== target && n < 64) begin
         tick();
         n++;
      end
      n_checks++;
      if (pc !== target) begin
         n_errors++;
         $display("FAIL run_to: pc=%h required=%h after %0d cycles", pc, target, n);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_mode = 0; m_left = 0; m_fv = 0; m_started = 0; m_wrap = 0;
   endtask

   task automatic model_advance();
      m_wrap = (m_pc == 4095);
      m_pc   = (m_pc + 1) % 4096;
   endtask

   task automatic model_step();
      bit first, busy;
      first     = !m_started;
      busy      = stall_i || md_busy;
      m_started = 1;
      m_wrap    = 0;
      if (redirect_valid) begin
         m_pc = int'(redirect_target); m_mode = 2; m_left = FC; m_fv = 1;
      end else if (m_mode == 0) begin
         if (halt_req) begin m_mode = 3; m_fv = 0; end
         else if (busy) begin m_mode = 1; m_fv = 1; end
         else if (first) m_fv = 1;
         else model_advance();
      end else if (m_mode == 1) begin
         if (halt_req) begin m_mode = 3; m_fv = 0; end
         else if (!busy) begin m_mode = 0; model_advance(); end
      end else if (m_mode == 2) begin
         if (!md_busy) model_advance();
         m_left = m_left - 1;
         if (m_left == 0) m_mode = 0;
      end else begin
         if (resume) begin m_mode = 0; m_fv = 1; end
      end
   endtask

   task automatic test_reset();
      idle();
      clr_n = 1'b1;
      #1 clr_n = 1'b0;
      #2;
      n_checks += 4;
      if (pc !== 12'h000) begin n_errors++; $display("FAIL reset_pc: pc=%h required=000", pc); end
      if (fetch_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv: fetch_valid=%b required=0", fetch_valid); end
      if (state !== 2'd0) begin n_errors++; $display("FAIL reset_state: state=%0d required=0", state); end
      if ({flush_fd, flush_dx, pc_wrap} !== 3'b000) begin
         n_errors++; $display("FAIL reset_flags: fd/dx/wrap=%b%b%b required=000", flush_fd, flush_dx, pc_wrap);
      end
      @(negedge clk);
      clr_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_checks += 3;
         if (pc !== PC_W'(k - 1)) begin n_errors++; $display("FAIL release_pc%0d: pc=%h required=%h", k, pc, PC_W'(k - 1)); end
         if (fetch_valid !== 1'b1) begin n_errors++; $display("FAIL release_fv%0d: fetch_valid=%b required=1", k, fetch_valid); end
         if ({flush_fd, flush_dx} !== 2'b00) begin n_errors++; $display("FAIL release_flush%0d: fd/dx=%b%b required=00", k, flush_fd, flush_dx); end
      end
   endtask

   task automatic test_stall();
      idle();
      run_to(12'h005);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks += 3;
         if (pc !== 12'h005) begin n_errors++; $display("FAIL stall_pc%0d: pc=%h required=005", k, pc); end
         if (state !== 2'd1) begin n_errors++; $display("FAIL stall_state%0d: state=%0d required=1", k, state); end
         if (fetch_valid !== 1'b1) begin n_errors++; $display("FAIL stall_fv%0d: fetch_valid=%b required=1", k, fetch_valid); end
      end
      stall_i = 1'b0;
      tick();
      n_checks += 2;
      if (pc !== 12'h006) begin n_errors++; $display("FAIL stall_release_pc: pc=%h required=006", pc); end
      if (state !== 2'd0) begin n_errors++; $display("FAIL stall_release_state: state=%0d required=0", state); end
   endtask

   task automatic test_redirect();
      logic [PC_W-1:0] exp_pc [3];
      logic            exp_fl [3];
      logic [1:0]      exp_st [3];
      exp_pc = '{12'h3A0, 12'h3A1, 12'h3A2};
      exp_fl = '{1'b1, 1'b1, 1'b0};
      exp_st = '{2'd2, 2'd2, 2'd0};
      idle();
      run_to(12'h010);
      for (int k = 0; k < 3; k++) begin
         redirect_valid  = (k == 0);
         redirect_target = 12'h3A0;
         tick();
         n_checks += 3;
         if (pc !== exp_pc[k]) begin n_errors++; $display("FAIL redir_pc%0d: pc=%h required=%h", k, pc, exp_pc[k]); end
         if (flush_fd !== exp_fl[k] || flush_dx !== exp_fl[k]) begin
            n_errors++; $display("FAIL redir_flush%0d: fd/dx=%b%b required=%b", k, flush_fd, flush_dx, exp_fl[k]);
         end
         if (state !== exp_st[k]) begin n_errors++; $display("FAIL redir_state%0d: state=%0d required=%0d", k, state, exp_st[k]); end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [PC_W-1:0] exp_pc [4];
      logic [1:0]      exp_st [4];
      int              highs;
      exp_pc = '{12'h100, 12'h200, 12'h201, 12'h202};
      exp_st = '{2'd2, 2'd2, 2'd2, 2'd0};
      highs  = 0;
      idle();
      stall_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         redirect_valid  = (k < 2);
         redirect_target = (k == 0) ? 12'h100 : 12'h200;
         tick();
         if (flush_fd && flush_dx) highs++;
         n_checks += 2;
         if (pc !== exp_pc[k]) begin n_errors++; $display("FAIL b2b_pc%0d: pc=%h required=%h", k, pc, exp_pc[k]); end
         if (state !== exp_st[k]) begin n_errors++; $display("FAIL b2b_state%0d: state=%0d required=%0d", k, state, exp_st[k]); end
      end
      n_checks++;
      if (highs != 3) begin n_errors++; $display("FAIL b2b_flush_len: high cycles=%0d required=3", highs); end
      idle();
   endtask

   task automatic test_halt_resume();
      idle();
      redirect_valid  = 1'b1;
      redirect_target = 12'h01C;
      tick();
      idle();
      run_to(12'h020);
      halt_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks += 3;
         if (state !== 2'd3) begin n_errors++; $display("FAIL halt_state%0d: state=%0d required=3", k, state); end
         if (fetch_valid !== 1'b0) begin n_errors++; $display("FAIL halt_fv%0d: fetch_valid=%b required=0", k, fetch_valid); end
         if (pc !== 12'h020) begin n_errors++; $display("FAIL halt_pc%0d: pc=%h required=020", k, pc); end
      end
      halt_req        = 1'b0;
      resume          = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 12'h050;
      tick();
      n_checks += 4;
      if (state !== 2'd2) begin n_errors++; $display("FAIL resume_redir_state: state=%0d required=2", state); end
      if (pc !== 12'h050) begin n_errors++; $display("FAIL resume_redir_pc: pc=%h required=050", pc); end
      if (fetch_valid !== 1'b1) begin n_errors++; $display("FAIL resume_redir_fv: fetch_valid=%b required=1", fetch_valid); end
      if (flush_fd !== 1'b1) begin n_errors++; $display("FAIL resume_redir_flush: flush_fd=%b required=1", flush_fd); end
      idle();
      tick();
      tick();
      n_checks++;
      if (state !== 2'd0 || pc !== 12'h052) begin
         n_errors++; $display("FAIL resume_settle: state=%0d pc=%h required state=0 pc=052", state, pc);
      end
   endtask

   task automatic test_wrap_and_async_reset();
      logic [PC_W-1:0] exp_pc [4];
      logic            exp_wr [4];
      int              wraps;
      exp_pc = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      exp_wr = '{1'b0, 1'b0, 1'b1, 1'b0};
      wraps  = 0;
      idle();
      for (int k = 0; k < 4; k++) begin
         redirect_valid  = (k == 0);
         redirect_target = 12'hFFE;
         tick();
         if (pc_wrap) wraps++;
         n_checks += 2;
         if (pc !== exp_pc[k]) begin n_errors++; $display("FAIL wrap_pc%0d: pc=%h required=%h", k, pc, exp_pc[k]); end
         if (pc_wrap !== exp_wr[k]) begin n_errors++; $display("FAIL wrap_pulse%0d: pc_wrap=%b required=%b", k, pc_wrap, exp_wr[k]); end
      end
      n_checks++;
      if (wraps != 1) begin n_errors++; $display("FAIL wrap_count: pulses=%0d required=1", wraps); end
      redirect_valid  = 1'b1;
      redirect_target = 12'h123;
      tick();
      idle();
      n_checks++;
      if (flush_fd !== 1'b1) begin n_errors++; $display("FAIL midflush_pre: flush_fd=%b required=1", flush_fd); end
      #2 clr_n = 1'b0;
      #1;
      n_checks += 3;
      if (pc !== 12'h000) begin n_errors++; $display("FAIL async_reset_pc: pc=%h required=000", pc); end
      if ({flush_fd, flush_dx} !== 2'b00) begin n_errors++; $display("FAIL async_reset_flush: fd/dx=%b%b required=00", flush_fd, flush_dx); end
      if (state !== 2'd0 || fetch_valid !== 1'b0) begin
         n_errors++; $display("FAIL async_reset_state: state=%0d fv=%b required state=0 fv=0", state, fetch_valid);
      end
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic test_random();
      idle();
      clr_n = 1'b0;
      model_reset();
      @(negedge clk);
      clr_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
         redirect_valid  = ($urandom_range(0, 9) == 0);
         redirect_target = ($urandom_range(0, 2) == 0) ? PC_W'(12'hFF0 + $urandom_range(0, 15))
                                                       : PC_W'($urandom_range(0, 4095));
         halt_req = ($urandom_range(0, 15) == 0);
         stall_i  = ($urandom_range(0, 4) == 0);
         md_busy  = ($urandom_range(0, 7) == 0);
         resume   = ($urandom_range(0, 3) == 0);
         model_step();
         tick();
         n_checks += 6;
         if (pc !== PC_W'(m_pc)) begin n_errors++; $display("FAIL rnd_pc c%0d: pc=%h required=%h", c, pc, PC_W'(m_pc)); end
         if (state !== 2'(m_mode)) begin n_errors++; $display("FAIL rnd_state c%0d: state=%0d required=%0d", c, state, m_mode); end
         if (fetch_valid !== m_fv) begin n_errors++; $display("FAIL rnd_fv c%0d: fetch_valid=%b required=%b", c, fetch_valid, m_fv); end
         if (flush_fd !== (m_mode == 2)) begin n_errors++; $display("FAIL rnd_flush_fd c%0d: flush_fd=%b required=%b", c, flush_fd, m_mode == 2); end
         if (flush_dx !== (m_mode == 2)) begin n_errors++; $display("FAIL rnd_flush_dx c%0d: flush_dx=%b required=%b", c, flush_dx, m_mode == 2); end
         if (pc_wrap !== m_wrap) begin n_errors++; $display("FAIL rnd_wrap c%0d: pc_wrap=%b required=%b", c, pc_wrap, m_wrap); end
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_halt_resume();
      test_wrap_and_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns and sequences the 12-bit program counter for the fetch stage.
- Each cycle picks the next PC by priority: redirect, halt, stall, increment.
- After a taken branch or jump, drives a timed flush of the wrong-path instructions in the F/D and D/X latches.
- Provides halt/resume control for the core.

Parameters:
- PC_W, 12, program counter width.
- RESET_PC, 12'h000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles the flush outputs stay asserted after a redirect; legal range 1..3.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  taken branch/jump/exception resolved this cycle.
- redirect_target  in  PC_W  destination PC for the redirect.
- stall_i  in  1  hazard-unit stall request.
- md_busy  in  1  mult/div unit busy; the PC must hold.
- halt_req  in  1  halt instruction decoded.
- resume  in  1  leave the HALT state.
- pc  out  PC_W  current fetch address, registered.
- fetch_valid  out  1  instruction-memory fetch at pc is valid, registered.
- flush_fd  out  1  kill the F/D latch contents, registered.
- flush_dx  out  1  kill the D/X latch contents, registered.
- pc_wrap  out  1  one-cycle pulse when pc wrapped from all-ones to 0.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (clr_n low, asynchronous) sets:
  - pc=RESET_PC, state=RUN, fetch_valid=0
  - flush_fd=0, flush_dx=0, pc_wrap=0, flush counter=0.
- Release of reset is sampled synchronously. fetch_valid rises at the first edge after clr_n goes high; pc stays RESET_PC on that edge.
- States: RUN=2'd0, STALL=2'd1, FLUSH=2'd2, HALT=2'd3.
- Priority, evaluated every edge in every state: redirect_valid > halt_req > (stall_i|md_busy) > normal.
- redirect_valid (any state, including HALT and FLUSH):
  - pc<=redirect_target; state<=FLUSH; counter<=FLUSH_CYCLES-1.
  - flush_fd<=1, flush_dx<=1, fetch_valid<=1.
  - A redirect during FLUSH reloads the counter, so the window restarts.
- FLUSH, no new redirect:
  - pc<=pc+1; stall_i is ignored, because the stall comes from flushed instructions.
  - md_busy is honoured: pc holds while the counter still decrements.
  - When counter==0, go to RUN and clear flush_fd/flush_dx at that edge.
  - Flush outputs are therefore high for exactly FLUSH_CYCLES cycles.
- halt_req in RUN or STALL:
  - state<=HALT, fetch_valid<=0, pc holds.
  - In HALT, pc holds and fetch_valid stays 0. resume moves to RUN with fetch_valid<=1 and the same pc. halt_req in HALT is ignored.
- stall_i|md_busy in RUN: state<=STALL, pc holds, fetch_valid stays 1.
- In STALL: stay while stall_i|md_busy; otherwise go to RUN with pc<=pc+1 at the same edge.
- Normal RUN: pc<=pc+1, modulo 2^PC_W. If pc==all-ones then pc<=0 and pc_wrap pulses for one cycle. No other pc_wrap sources exist; a redirect target of 0 does not pulse it.
- Resume together with redirect: the redirect wins (goes to FLUSH).
- Reset mid-FLUSH: flushes drop immediately (asynchronously); counter cleared.

Decomposition:
- Shared package pc_seq_pkg:
  - PC_W
  - state encodings RUN/STALL/FLUSH/HALT
  - FLUSH_CYCLES default
  - flush counter width (2).
- One natural sub-module, pc_reg_en: PC_W-bit enabled register with async active-low clear to RESET_PC, instantiated for the pc. The FSM, counter and next-PC mux stay in pc_sequencer.

Test Plan:
- Reset, then release clr_n, 4 idle cycles: pc goes 000,000,001,002,003; fetch_valid=1 from the 1st edge; all flushes 0.
- At pc=005 assert stall_i for 3 cycles: pc holds 005 for 3 cycles, state=STALL, then pc=006 on the release edge.
- At pc=010 pulse redirect_valid with target 12'h3A0 (FLUSH_CYCLES=2): pc=3A0, then 3A1; flush_fd/dx high exactly 2 cycles, then state=RUN.
- Redirect to 0x100, then a second redirect to 0x200 one cycle later, with stall_i held high throughout: pc=100 then 200; stall ignored; flush high 3 cycles total.
- halt_req at pc=020: state=HALT, fetch_valid=0, pc=020 for 5 cycles. Then resume together with redirect to 0x050: goes to FLUSH with pc=050.
- Wrap and reset corner:
  - Redirect to 0xFFE, then run: pc FFE, FFF, 000 with a single-cycle pc_wrap.
  - Drop clr_n mid-flush: pc=000 and flushes 0 asynchronously, without waiting for a clock edge.
